game_timer: RTL and testbench

- Multi-channel tick-based timeout generator for the BlackJack datapath. It generalises the single 2-second counter.
- An internal prescaler derives the game tick from clk_50M, so no second clock domain is needed.
- Provides CHANNELS independent one-shot timers with a programmable terminal count, plus a free-running seed counter used as the entropy source for card shuffling.
- Sits between the button debouncers and the game FSM. The FSM starts timers and consumes their expiry pulses.

---
 rtl/game_timer.sv | 193 +++++++++++++++++++
 tb/tb_game_timer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: multi-channel tick-based timeout generator.
//
// A prescaler divides clk_50M down to a game tick (DIV = CLK_HZ/TICK_HZ).
// Each of CHANNELS independent timers counts ticks up to a terminal value
// that is latched at start. On reaching it, the timer raises a one-clock
// expiry pulse and a sticky done flag. A free-running seed counter supplies
// entropy for card shuffling and is independent of the timers.
//
// Optional build macro GAME_TIMER_AUTORELOAD_EN: when defined, a channel with
// i_Reload[k]=1 at its expiry edge restarts counting from 0 and stays in RUN
// (periodic mode). When undefined, i_Reload is ignored and every channel is
// one-shot.
//
// All logic is on the rising edge of clk_50M. i_Reset is synchronous and
// active-low, and it overrides every other input.

module game_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 2000,
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
) (
  input  logic                      clk_50M,
  input  logic                      i_Reset,
  input  logic                      i_Zero,
  input  logic                      i_Seed_En,
  input  logic [CHANNELS-1:0]       i_Start,
  input  logic [CHANNELS-1:0]       i_Cancel,
  input  logic [CHANNELS-1:0]       i_Reload,
  input  logic [CHANNELS*WIDTH-1:0] i_Term,
  output logic                      o_Tick,
  output logic [CHANNELS-1:0]       o_Busy,
  output logic [CHANNELS-1:0]       o_Expired,
  output logic [CHANNELS-1:0]       o_Done,
  output logic [CHANNELS*WIDTH-1:0] o_Count,
  output logic [WIDTH-1:0]          o_Seed
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  // Last prescaler value (tick cycle) and the value just before it.
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(DIV - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Periodic-mode enable per channel
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] reload_en;

`ifdef GAME_TIMER_AUTORELOAD_EN
  assign reload_en = i_Reload;
`else
  // The port stays in the interface but carries no function in this build.
  logic unused_reload;
  assign reload_en     = '0;
  assign unused_reload = ^i_Reload;
`endif

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick_q;

  // Free-running 0..DIV-1 counter. The tick register is loaded one cycle
  // early, so it is high exactly while the prescaler holds DIV-1.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk_50M) begin
    if (!i_Reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      tick_q  <= (presc_q == PRESC_PRE);
    end
  end

  assign o_Tick = tick_q;

  // --------------------------------------------------------------------------
  // Seed counter
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] seed_q;

  // Clear has priority over increment. The counter wraps naturally at 2^WIDTH.
  always_ff @(posedge clk_50M) begin
    if (!i_Reset) begin
      seed_q <= '0;
    end else if (i_Zero) begin
      seed_q <= '0;
    end else if (i_Seed_En) begin
      seed_q <= seed_q + WIDTH'(1);
    end
  end

  assign o_Seed = seed_q;

  // --------------------------------------------------------------------------
  // Timer channels
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] term_q;
    logic             busy_q;
    logic             expired_q;
    logic             done_q;

    logic [WIDTH-1:0] term_eff;
    logic [WIDTH-1:0] count_inc;
    logic             counting;
    logic             hit;
    logic             load_term;

    // A terminal count of zero expires on the first tick, the same as one.
    assign term_eff  = (term_q == '0) ? WIDTH'(1) : term_q;
    assign count_inc = count_q + WIDTH'(1);
    assign counting  = (state_q == S_RUN) && tick_q;
    assign hit       = counting && (count_inc == term_eff);

    // A start that is not overridden by cancel or reset captures the terminal
    // count. Later changes on i_Term wait for the next start.
    assign load_term = i_Reset && i_Start[k] && !i_Cancel[k];

    // Terminal count capture register.
    // NOTE: term_q is deliberately not reset. It is only read in RUN, and RUN
    // can only be entered through a start that loads it in the same edge.
    always_ff @(posedge clk_50M) begin
      if (load_term) begin
        term_q <= i_Term[k*WIDTH +: WIDTH];
      end
    end

    // Channel FSM with registered outputs. Priority: reset, cancel, start,
    // expiry, then plain counting. The expiry pulse defaults low every cycle,
    // so it lasts exactly one clock.
    always_ff @(posedge clk_50M) begin
      if (!i_Reset) begin
        state_q   <= S_IDLE;
        count_q   <= '0;
        busy_q    <= 1'b0;
        expired_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        expired_q <= 1'b0;
        if (i_Cancel[k]) begin
          state_q <= S_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end else if (i_Start[k]) begin
          // The start edge also swallows any expiry that would occur here.
          state_q <= S_RUN;
          count_q <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end else if (hit) begin
          expired_q <= 1'b1;
          done_q    <= 1'b1;
          if (reload_en[k]) begin
            // Periodic mode: begin the next period, stay busy.
            count_q <= '0;
          end else begin
            // One-shot: park at the raw latched terminal count. For a
            // terminal count of zero this keeps the count at zero.
            state_q <= S_DONE;
            count_q <= term_q;
            busy_q  <= 1'b0;
          end
        end else if (counting) begin
          count_q <= count_inc;
        end
      end
    end

    assign o_Busy[k]                   = busy_q;
    assign o_Expired[k]                = expired_q;
    assign o_Done[k]                   = done_q;
    assign o_Count[k*WIDTH +: WIDTH]   = count_q;
  end

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: self-checking bench for game_timer.
// Configuration: CLK_HZ=10, TICK_HZ=2 (DIV=5), WIDTH=4, CHANNELS=2.
// Directed scenario tasks compare against hand-derived constants. The random
// task compares every cycle against a behavioural model that counts ticks
// per channel in plain integers.

module tb_game_timer;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int W       = 4;
  localparam int CH      = 2;
  localparam int VW      = 1 + 3*CH + CH*W + W;

`ifdef GAME_TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            zero;
  logic            seed_en;
  logic [CH-1:0]   start;
  logic [CH-1:0]   cancel;
  logic [CH-1:0]   reload;
  logic [CH*W-1:0] term;

  logic            tick;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   expired;
  logic [CH-1:0]   done;
  logic [CH*W-1:0] count;
  logic [W-1:0]    seed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_timer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .WIDTH   (W),
    .CHANNELS(CH)
  ) dut (
    .clk_50M  (clk),
    .i_Reset  (reset_n),
    .i_Zero   (zero),
    .i_Seed_En(seed_en),
    .i_Start  (start),
    .i_Cancel (cancel),
    .i_Reload (reload),
    .i_Term   (term),
    .o_Tick   (tick),
    .o_Busy   (busy),
    .o_Expired(expired),
    .o_Done   (done),
    .o_Count  (count),
    .o_Seed   (seed)
  );

  // ------------------------------------------------------------------------
  // Behavioural model: cycles since reset, per-channel mode and tick tally.
  // mode: 0 idle, 1 running, 2 finished.
  // ------------------------------------------------------------------------
  int m_cyc = 0;
  int m_seed = 0;
  int m_mode [CH];
  int m_ticks[CH];
  int m_term [CH];
  bit m_exp  [CH];
  bit m_done [CH];

  initial begin
    for (int k = 0; k < CH; k++) begin
      m_mode[k] = 0; m_ticks[k] = 0; m_term[k] = 0; m_exp[k] = 0; m_done[k] = 0;
    end
  end

  // Advance the model by one edge using the current inputs, then advance the
  // DUT by one edge and settle just after it.
  task automatic cycle();
    bit tk;
    int target;
    tk = ((m_cyc % DIV) == DIV - 1);
    if (!reset_n) begin
      m_cyc  = 0;
      m_seed = 0;
      for (int k = 0; k < CH; k++) begin
        m_mode[k] = 0; m_ticks[k] = 0; m_exp[k] = 0; m_done[k] = 0;
      end
    end else begin
      m_cyc++;
      for (int k = 0; k < CH; k++) begin
        m_exp[k] = 0;
        if (cancel[k]) begin
          m_mode[k] = 0; m_ticks[k] = 0; m_done[k] = 0;
        end else if (start[k]) begin
          m_mode[k] = 1; m_ticks[k] = 0; m_done[k] = 0;
          m_term[k] = int'(term[k*W +: W]);
        end else if (m_mode[k] == 1 && tk) begin
          m_ticks[k]++;
          target = (m_term[k] == 0) ? 1 : m_term[k];
          if (m_ticks[k] >= target) begin
            m_exp[k]  = 1;
            m_done[k] = 1;
            if (AUTORELOAD && reload[k]) m_ticks[k] = 0;
            else m_mode[k] = 2;
          end
        end
      end
      if (zero) m_seed = 0;
      else if (seed_en) m_seed = (m_seed + 1) % (1 << W);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [CH-1:0]   b;
    logic [CH-1:0]   e;
    logic [CH-1:0]   d;
    logic [CH*W-1:0] c;
    for (int k = 0; k < CH; k++) begin
      b[k] = (m_mode[k] == 1);
      e[k] = m_exp[k];
      d[k] = m_done[k];
      c[k*W +: W] = W'((m_mode[k] == 2) ? m_term[k] : m_ticks[k]);
    end
    return {((m_cyc % DIV) == DIV - 1), b, e, d, c, W'(m_seed)};
  endfunction

  // Step until the current cycle is a tick cycle (at most DIV-1 steps).
  task automatic align_tick();
    for (int i = 0; i < DIV; i++) begin
      if ((m_cyc % DIV) == DIV - 1) break;
      cycle();
    end
  endtask

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  task automatic test_reset();
    logic [VW-1:0] got;
    reset_n = 1'b0; zero = 1'b0; seed_en = 1'b0;
    start = '0; cancel = '0; reload = '0; term = '0;
    cycle();
    cycle();
    got = {tick, busy, expired, done, count, seed};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", got);
    end
    reset_n = 1'b1;
    // Cycle j after the last reset edge: tick only when j mod DIV == DIV-1.
    for (int j = 0; j < 12; j++) begin
      if (j > 0) cycle();
      got = {tick, busy, expired, done, count, seed};
      n_cmp++;
      if (got !== {((j % DIV) == DIV - 1), (VW-1)'(0)}) begin
        n_bad++; $display("FAIL tick_phase[j=%0d]: got %h tick=%b", j, got, tick);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W+2:0] got, want;
    align_tick();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++; $display("FAIL one_shot_align: tick=%b want 1", tick);
    end
    start[0] = 1'b1; term[W-1:0] = W'(3);
    cycle();
    start[0] = 1'b0; term[W-1:0] = W'(1);   // must not affect the running timer
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) cycle();
      got  = {busy[0], expired[0], done[0], count[W-1:0]};
      want = {(j < 15), (j == 15), (j >= 15), W'((j < 15) ? j / DIV : 3)};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL one_shot[j=%0d]: busy/exp/done/count got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_cancel();
    logic [W+2:0] got;
    align_tick();
    start[1] = 1'b1; term[2*W-1:W] = W'(4);
    cycle();
    start[1] = 1'b0;
    repeat (10) cycle();
    n_cmp++;
    if ({busy[1], count[2*W-1:W]} !== {1'b1, W'(2)}) begin
      n_bad++; $display("FAIL cancel_pre: busy=%b count=%0d want busy=1 count=2", busy[1], count[2*W-1:W]);
    end
    cancel[1] = 1'b1;
    cycle();
    cancel[1] = 1'b0;
    got = {busy[1], expired[1], done[1], count[2*W-1:W]};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL cancel_idle: busy/exp/done/count got %b want 0", got);
    end
    for (int j = 0; j < 25; j++) begin
      cycle();
      n_cmp++;
      if ({busy[1], expired[1], count[2*W-1:W]} !== '0) begin
        n_bad++; $display("FAIL cancel_quiet[j=%0d]: busy=%b exp=%b count=%0d want 0", j, busy[1], expired[1], count[2*W-1:W]);
      end
    end
    start[1] = 1'b1; cancel[1] = 1'b1;
    cycle();
    start[1] = 1'b0; cancel[1] = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (j > 0) cycle();
      n_cmp++;
      if ({busy[1], expired[1], done[1], count[2*W-1:W]} !== '0) begin
        n_bad++; $display("FAIL cancel_wins[j=%0d]: busy=%b exp=%b done=%b count=%0d want 0", j, busy[1], expired[1], done[1], count[2*W-1:W]);
      end
    end
  endtask

  task automatic test_restart_at_expiry();
    logic [W+2:0] got, want;
    align_tick();
    start[0] = 1'b1; term[W-1:0] = W'(2);
    cycle();
    start[0] = 1'b0;
    repeat (9) cycle();
    // Current cycle is the tick whose edge would expire the channel.
    n_cmp++;
    if ({tick, busy[0], count[W-1:0]} !== {1'b1, 1'b1, W'(1)}) begin
      n_bad++; $display("FAIL restart_pre: tick=%b busy=%b count=%0d want 1 1 1", tick, busy[0], count[W-1:0]);
    end
    start[0] = 1'b1;
    cycle();
    start[0] = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) cycle();
      got  = {busy[0], expired[0], done[0], count[W-1:0]};
      want = (j < 10) ? {3'b100, W'(j / DIV)} : {3'b011, W'(2)};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL restart[j=%0d]: busy/exp/done/count got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_term_zero();
    logic [W+2:0] got, want;
    align_tick();
    start[0] = 1'b1; term[W-1:0] = W'(0);
    cycle();
    start[0] = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cycle();
      got  = {busy[0], expired[0], done[0], count[W-1:0]};
      want = {(j < 5), (j == 5), (j >= 5), W'(0)};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL term_zero[j=%0d]: busy/exp/done/count got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_seed();
    zero = 1'b1;
    cycle();
    zero = 1'b0; seed_en = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      cycle();
      n_cmp++;
      if (seed !== W'(j % 16)) begin
        n_bad++; $display("FAIL seed_count[j=%0d]: got %0d want %0d", j, seed, j % 16);
      end
    end
    zero = 1'b1;   // seed_en still high: clear wins
    cycle();
    n_cmp++;
    if (seed !== W'(0)) begin
      n_bad++; $display("FAIL seed_zero: got %0d want 0", seed);
    end
    zero = 1'b0;
    cycle();
    seed_en = 1'b0;
    cycle();
    n_cmp++;
    if (seed !== W'(1)) begin
      n_bad++; $display("FAIL seed_hold: got %0d want 1", seed);
    end
  endtask

  task automatic test_reset_midrun();
    logic [VW-1:0] got;
    align_tick();
    start = 2'b11; term = {W'(4), W'(3)}; seed_en = 1'b1;
    cycle();
    start = '0;
    repeat (14) cycle();
    // Channel 0 would expire at the coming edge.
    n_cmp++;
    if ({busy, count} !== {2'b11, W'(2), W'(2)}) begin
      n_bad++; $display("FAIL reset_mid_pre: busy=%b count=%h want 11 22", busy, count);
    end
    reset_n = 1'b0;
    cycle();
    got = {tick, busy, expired, done, count, seed};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL reset_mid: got %h want 0", got);
    end
    reset_n = 1'b1; seed_en = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      cycle();
      n_cmp++;
      if ({tick, busy, expired, done} !== {((j % DIV) == DIV - 1), 6'b0}) begin
        n_bad++; $display("FAIL reset_mid_after[j=%0d]: tick=%b busy=%b exp=%b done=%b", j, tick, busy, expired, done);
      end
    end
  endtask

  task automatic test_reload();
    logic [W+2:0] got, want;
    align_tick();
    reload[0] = 1'b1; start[0] = 1'b1; term[W-1:0] = W'(2);
    cycle();
    start[0] = 1'b0;
    for (int j = 1; j <= 35; j++) begin
      cycle();
      got = {busy[0], expired[0], done[0], count[W-1:0]};
`ifdef GAME_TIMER_AUTORELOAD_EN
      want = {1'b1, ((j % 10) == 0), (j >= 10), W'((j % 10) / DIV)};
`else
      want = {(j < 10), (j == 10), (j >= 10), W'((j < 10) ? j / DIV : 2)};
`endif
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reload[j=%0d]: busy/exp/done/count got %b want %b", j, got, want);
      end
    end
    reload[0] = 1'b0;
    cancel[0] = 1'b1;
    cycle();
    cancel[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [VW-1:0] got, want;
    reset_n = 1'b0; zero = 1'b0; seed_en = 1'b0;
    start = '0; cancel = '0; reload = '0;
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      zero    = ($urandom_range(0, 24) == 0);
      seed_en = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < CH; k++) begin
        start[k]    = ($urandom_range(0, 29) == 0);
        cancel[k]   = ($urandom_range(0, 59) == 0);
        reload[k]   = ($urandom_range(0, 1) == 1);
        term[k*W +: W] = W'($urandom_range(0, 5));
      end
      cycle();
      got  = {tick, busy, expired, done, count, seed};
      want = model_vec();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, got, want);
      end
    end
    reset_n = 1'b1; zero = 1'b0; seed_en = 1'b0;
    start = '0; cancel = '0; reload = '0;
  endtask

  // ------------------------------------------------------------------------
  // Sequencer and watchdog
  // ------------------------------------------------------------------------
  initial begin
    test_reset();
    test_one_shot();
    test_cancel();
    test_restart_at_expiry();
    test_term_zero();
    test_seed();
    test_reset_midrun();
    test_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
